// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchroniser, stability-qualified level FSM,
// registered one-cycle press/release strobes and a wrapping press counter.
module button_debouncer #(
  parameter int CLK_ITER_WIDTH  = 2,
  parameter int CLK_ITER_MAX    = 2,
  parameter int PRESS_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rstInput,
  input  logic                       btnInput,
  output logic                       btnLevel,
  output logic                       pressPulse,
  output logic                       releasePulse,
  output logic [PRESS_CNT_WIDTH-1:0] pressCount,
  output logic                       busy
);

  typedef enum logic [1:0] {
    S_LOW,
    S_ARM_HIGH,
    S_HIGH,
    S_ARM_LOW
  } state_t;

  localparam logic [CLK_ITER_WIDTH-1:0] ITER_MAX = CLK_ITER_WIDTH'(CLK_ITER_MAX);
  localparam logic [CLK_ITER_WIDTH-1:0] ITER_ONE = CLK_ITER_WIDTH'(1);
  localparam bit                        NO_ARM   = (CLK_ITER_MAX == 0);

  logic                       sync1_q, sync2_q;
  state_t                     state_q, state_d;
  logic [CLK_ITER_WIDTH-1:0]  iter_q, iter_d;
  logic                       level_q, level_d;
  logic                       press_q, press_d;
  logic                       release_q, release_d;
  logic [PRESS_CNT_WIDTH-1:0] count_q, count_d;
  logic                       busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    count_d   = count_q;

    unique case (state_q)
      S_LOW: begin
        if (sync2_q) begin
          // With no qualification window the first disagreeing sample is accepted.
          if (NO_ARM) begin
            state_d = S_HIGH;
            level_d = 1'b1;
            press_d = 1'b1;
            count_d = count_q + PRESS_CNT_WIDTH'(1);
            iter_d  = '0;
          end else begin
            state_d = S_ARM_HIGH;
            iter_d  = ITER_ONE;
          end
        end
      end
      S_ARM_HIGH: begin
        if (!sync2_q) begin
          state_d = S_LOW;
          iter_d  = '0;
        end else if (iter_q >= ITER_MAX) begin
          state_d = S_HIGH;
          level_d = 1'b1;
          press_d = 1'b1;
          count_d = count_q + PRESS_CNT_WIDTH'(1);
          iter_d  = '0;
        end else begin
          iter_d = iter_q + ITER_ONE;
        end
      end
      S_HIGH: begin
        if (!sync2_q) begin
          if (NO_ARM) begin
            state_d   = S_LOW;
            level_d   = 1'b0;
            release_d = 1'b1;
            iter_d    = '0;
          end else begin
            state_d = S_ARM_LOW;
            iter_d  = ITER_ONE;
          end
        end
      end
      S_ARM_LOW: begin
        if (sync2_q) begin
          state_d = S_HIGH;
          iter_d  = '0;
        end else if (iter_q >= ITER_MAX) begin
          state_d   = S_LOW;
          level_d   = 1'b0;
          release_d = 1'b1;
          iter_d    = '0;
        end else begin
          iter_d = iter_q + ITER_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        iter_d  = '0;
      end
    endcase

    busy_d = (state_d == S_ARM_HIGH) || (state_d == S_ARM_LOW);
  end

  always_ff @(posedge clk) begin
    if (rstInput) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= S_LOW;
      iter_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      sync1_q   <= btnInput;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      iter_q    <= iter_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
    end
  end

  assign btnLevel     = level_q;
  assign pressPulse   = press_q;
  assign releasePulse = release_q;
  assign pressCount   = count_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: a run-length debounce model checked every cycle,
// directed scenarios with literal expectations, and a random bounce burst.
`timescale 1ns/1ps
module tb_button_debouncer;

  localparam int ITW  = 2;
  localparam int IMAX = 2;
  localparam int PCW  = 2;

  logic           clk = 1'b0;
  logic           rstInput = 1'b1;
  logic           btnInput = 1'b0;
  logic           btnLevel, pressPulse, releasePulse, busy;
  logic [PCW-1:0] pressCount;

  button_debouncer #(
    .CLK_ITER_WIDTH (ITW),
    .CLK_ITER_MAX   (IMAX),
    .PRESS_CNT_WIDTH(PCW)
  ) dut (
    .clk         (clk),
    .rstInput    (rstInput),
    .btnInput    (btnInput),
    .btnLevel    (btnLevel),
    .pressPulse  (pressPulse),
    .releasePulse(releasePulse),
    .pressCount  (pressCount),
    .busy        (busy)
  );

  always #41.667 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the accepted level flips once the synchronised input has disagreed with it
  // for IMAX+1 consecutive samples; any agreeing sample restarts the run.
  int m_s1, m_s2, m_level, m_run, m_press, m_rel, m_count, m_busy;
  always @(posedge clk) begin
    int s2_old;
    if (rstInput) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0;
      m_press = 0; m_rel = 0; m_count = 0; m_busy = 0;
    end else begin
      s2_old = m_s2;
      m_s2 = m_s1;
      m_s1 = int'(btnInput);
      m_press = 0;
      m_rel = 0;
      if (s2_old != m_level) begin
        m_run++;
        if (m_run == IMAX + 1) begin
          m_level = s2_old;
          m_run = 0;
          if (m_level == 1) begin
            m_press = 1;
            m_count = (m_count + 1) % (1 << PCW);
          end else begin
            m_rel = 1;
          end
        end
      end else begin
        m_run = 0;
      end
      m_busy = (m_run != 0) ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("level", int'(btnLevel), m_level);
      chk("press", int'(pressPulse), m_press);
      chk("release", int'(releasePulse), m_rel);
      chk("count", int'(pressCount), m_count);
      chk("busy", int'(busy), m_busy);
      chk("strobe_excl", int'(pressPulse && releasePulse), 0);
    end
  end

  int press_seen, rel_seen, busy_seen;

  task automatic cyc(input logic b, input logic r);
    btnInput = b;
    rstInput = r;
    @(posedge clk);
    #1;
    if (pressPulse)   press_seen++;
    if (releasePulse) rel_seen++;
    if (busy)         busy_seen++;
  endtask

  task automatic clear_seen();
    press_seen = 0;
    rel_seen   = 0;
    busy_seen  = 0;
  endtask

  initial begin
    logic [4:0] bounce;
    clear_seen();
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk_en = 1'b1;
    chk("rst_level", int'(btnLevel), 0);
    chk("rst_count", int'(pressCount), 0);
    chk("rst_busy", int'(busy), 0);

    // Clean press: input set up before edge 0
    clear_seen();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
    chk("s1_level_e3", int'(btnLevel), 0);
    cyc(1'b1, 1'b0);
    chk("s1_level_e4", int'(btnLevel), 1);
    chk("s1_press_e4", int'(pressPulse), 1);
    chk("s1_count", int'(pressCount), 1);
    cyc(1'b1, 1'b0);
    chk("s1_press_e5", int'(pressPulse), 0);
    for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0);
    chk("s1_presses", press_seen, 1);

    // Release
    clear_seen();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
    chk("s3_level_e3", int'(btnLevel), 1);
    cyc(1'b0, 1'b0);
    chk("s3_release_e4", int'(releasePulse), 1);
    chk("s3_level_e4", int'(btnLevel), 0);
    cyc(1'b0, 1'b0);
    chk("s3_release_e5", int'(releasePulse), 0);
    chk("s3_count", int'(pressCount), 1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);

    // Bounce that never holds long enough
    clear_seen();
    bounce = 5'b01101;
    for (int i = 0; i < 5; i++) cyc(bounce[i], 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0);
    chk("s2_level", int'(btnLevel), 0);
    chk("s2_presses", press_seen, 0);
    chk("s2_busy_seen", int'(busy_seen > 0), 1);
    chk("s2_count", int'(pressCount), 1);

    // Wrap after reset: counts 1,2,3,0
    cyc(1'b0, 1'b1);
    clear_seen();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0);
      chk("s4_count", int'(pressCount), (p + 1) % 4);
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0);
    end
    chk("s4_presses", press_seen, 4);
    chk("s4_releases", rel_seen, 4);

    // Reset mid-qualification
    clear_seen();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    chk("s5_busy_pre", int'(busy), 1);
    cyc(1'b1, 1'b1);
    chk("s5_level_rst", int'(btnLevel), 0);
    chk("s5_busy_rst", int'(busy), 0);
    chk("s5_count_rst", int'(pressCount), 0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
    chk("s5_level_e3", int'(btnLevel), 0);
    chk("s5_presses_e3", press_seen, 0);
    cyc(1'b1, 1'b0);
    chk("s5_level_e4", int'(btnLevel), 1);
    chk("s5_press_e4", int'(pressPulse), 1);
    chk("s5_count", int'(pressCount), 1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0);

    // Random bounce burst, then settle high and release
    for (int r = 0; r < 4; r++) begin
      clear_seen();
      for (int i = 0; i < 32; i++) cyc(1'($urandom % 2), 1'b0);
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0);
      chk("s6_level_high", int'(btnLevel), 1);
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0);
      chk("s6_level_low", int'(btnLevel), 0);
      chk("s6_balanced", press_seen - rel_seen, 0);
      chk("s6_some_press", int'(press_seen >= 1), 1);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
